sync_rom: RTL and testbench



---
 rtl/rom_pkg.sv | 25 ++
 rtl/sync_rom.sv | 39 +++
 tb/tb_sync_rom.sv | 79 +++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared constants and the content function for the synchronous lookup ROM.
// RTL and bench both use rom_word, so WORD(a) has a single definition.
package rom_pkg;

    localparam int ROM_N  = 8;
    localparam int ROM_SZ = 32;

    localparam logic [63:0] ROM_MUL = 64'h1D;
    localparam logic [63:0] ROM_ADD = 64'h3C;

    // Arithmetic runs at 64 bits so any n up to 32 has at least 2n bits of headroom
    // before truncation to n bits.
    function automatic logic [63:0] rom_word(input int unsigned a,
                                             input int unsigned n,
                                             input int unsigned sz);
        logic [63:0] full;
        full = 64'(a) * ROM_MUL + ROM_ADD;
        if (a >= sz)
            return 64'h0;
        if (n >= 64)
            return full;
        return full & ((64'h1 << n) - 64'h1);
    endfunction

endpackage

// File: rtl/sync_rom.sv
// Synchronous read-only table: constant contents built at elaboration from
// rom_word, one registered read per clock, synchronous active-low reset.
module sync_rom
    import rom_pkg::*;
#(
    parameter int N  = ROM_N,
    parameter int SZ = ROM_SZ
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] iaddr,
    output logic [N-1:0] o
);

    localparam longint DEPTH = longint'(1) << N;

    if (SZ < 1 || longint'(SZ) > DEPTH) begin : g_bad_size
        $fatal(1, "sync_rom: SZ=%0d outside 1..2**N (N=%0d)", SZ, N);
    end

    // Every address decodes to a constant, so the array folds into LUT/ROM
    // logic; entries at or above SZ are zero through rom_word itself.
    logic [N-1:0] rom [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = N'(rom_word(a, N, SZ));
    end

    // NOTE: the output register uses non-blocking assignment so every reader
    // of o sees the value from before this edge; reset is tested first so it
    // overrides the read on the same edge.
    always_ff @(posedge clk) begin
        if (!reset)
            o <= '0;
        else
            o <= rom[iaddr];
    end

endmodule

// File: tb/tb_sync_rom.sv
// Directed bench for sync_rom: reset, sequential reads, wrap, out-of-range,
// mid-cycle address stability and a one-edge reset in the middle of streaming.
module tb_sync_rom;

    logic       clk;
    logic       reset;
    logic [7:0] iaddr;
    logic [7:0] o;

    int total = 0;
    int bad   = 0;

    sync_rom #(.N(8), .SZ(32)) dut (
        .clk   (clk),
        .reset (reset),
        .iaddr (iaddr),
        .o     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: o=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        iaddr = 8'h05;

        // Reset held for two edges with a live address
        step(); check("reset_edge1", o, 8'h00);
        step(); check("reset_edge2", o, 8'h00);
        reset = 1'b1;
        step(); check("release_addr05", o, 8'hCD);

        // Sequential reads
        iaddr = 8'h00; step(); check("read_00", o, 8'h3C);
        iaddr = 8'h01; step(); check("read_01", o, 8'h59);
        iaddr = 8'h02; step(); check("read_02", o, 8'h76);
        iaddr = 8'h03; step(); check("read_03", o, 8'h93);

        // Wrap and last valid word
        iaddr = 8'h07; step(); check("wrap_07", o, 8'h07);
        iaddr = 8'h1F; step(); check("last_1f", o, 8'hBF);

        // Out of range
        iaddr = 8'h20; step(); check("oor_20", o, 8'h00);
        iaddr = 8'hFF; step(); check("oor_ff", o, 8'h00);

        // Address change between edges must not reach o early
        iaddr = 8'h01; step(); check("stable_pre", o, 8'h59);
        #3 iaddr = 8'h02;
        #2 check("stable_mid", o, 8'h59);
        step(); check("stable_post", o, 8'h76);

        // One-edge reset while streaming
        iaddr = 8'h03; step(); check("stream_03", o, 8'h93);
        reset = 1'b0;
        iaddr = 8'h04; step(); check("midreset", o, 8'h00);
        reset = 1'b1;
        step(); check("after_midreset_04", o, 8'hB0);
        iaddr = 8'h05; step(); check("after_midreset_05", o, 8'hCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
